message_input_parser: RTL and testbench
=======================================

MESSAGE_INPUT_PARSER -- requirements
Module: message_input_parser

Interface
REQ-001 The block SHALL have parameter GRID_WIDTH_X, default 3, meaning the X extent of the PU grid.
REQ-002 The block SHALL have parameter GRID_WIDTH_Z, default 2, meaning the Z extent of the PU grid.
REQ-003 The block SHALL have parameter GRID_WIDTH_U, default 3, meaning the number of measurement rounds.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port input_data, input, 8 bits, the host byte stream.
REQ-007 The block SHALL have port input_valid, input, 1 bit, meaning input_data carries a byte.
REQ-008 The block SHALL have port input_ready, output, 1 bit; a byte transfers on input_valid && input_ready.
REQ-009 The block SHALL have port start_pulse, output, 1 bit, a one-cycle decoder-arm strobe.
REQ-010 The block SHALL have port measurements, output, PU_COUNT bits, the compacted syndrome of one frame.
REQ-011 The block SHALL have port measurements_valid, output, 1 bit, meaning measurements holds a complete frame.
REQ-012 The block SHALL have port measurements_ready, input, 1 bit; a frame transfers on measurements_valid && measurements_ready.
REQ-013 The block SHALL have port error_count, output, 8 bits, the saturating count of dropped bytes.

Function
REQ-014 Derived constants SHALL be PU_PER_ROUND = GRID_WIDTH_X*GRID_WIDTH_Z, BYTES_PER_ROUND = ceil(PU_PER_ROUND/8), FRAME_BYTES = BYTES_PER_ROUND*GRID_WIDTH_U, and PU_COUNT = PU_PER_ROUND*GRID_WIDTH_U.
REQ-015 The FSM SHALL have four states: WAIT_START, IDLE, LOAD and HOLD.
REQ-016 In WAIT_START, an accepted START_DECODING_MSG SHALL move the FSM to IDLE and raise start_pulse for the next cycle only; any other accepted byte SHALL be dropped and SHALL increment error_count.
REQ-017 In IDLE, an accepted MEASUREMENT_DATA_HEADER SHALL move the FSM to LOAD and clear the byte counter.
REQ-018 In IDLE, an accepted START_DECODING_MSG SHALL re-pulse start_pulse and keep the FSM in IDLE.
REQ-019 In IDLE, any other accepted byte SHALL be dropped and SHALL increment error_count.
REQ-020 In LOAD, accepted byte n (0..FRAME_BYTES-1) SHALL be stored at padded-buffer bits [8n+7:8n], with no header interpretation in this state.
REQ-021 In LOAD, acceptance of byte FRAME_BYTES-1 SHALL move the FSM to HOLD.
REQ-022 Compaction SHALL map padded bit (i*GRID_WIDTH_Z + j + k*BYTES_PER_ROUND*8) to measurements bit (i*GRID_WIDTH_Z + j + k*PU_PER_ROUND); pad bits SHALL be discarded.
REQ-023 measurements SHALL be registered and stable throughout HOLD.
REQ-024 input_ready SHALL be 1 in WAIT_START, IDLE and LOAD, and 0 in HOLD.
REQ-025 input_ready SHALL be a function of the registered state only, with no combinational path from measurements_ready.
REQ-026 measurements_valid SHALL be 1 exactly in HOLD.
REQ-027 A handshake in HOLD SHALL return the FSM to IDLE on the next cycle.
REQ-028 Latency: if the last frame byte is accepted in cycle t, measurements_valid SHALL be high in cycle t+1.
REQ-029 If measurements_ready is held high, measurements_valid SHALL fall in cycle t+2 and input_ready SHALL rise in cycle t+2.
REQ-030 error_count SHALL saturate at 8'hFF.
REQ-031 input_valid low in any state SHALL leave the state and the byte counter unchanged (stall tolerance).

Reset
REQ-032 While reset is high, the state SHALL be WAIT_START, input_ready SHALL be 1, start_pulse=0, measurements_valid=0, measurements=0, error_count=0, and the byte counter=0.
REQ-033 A reset asserted mid-LOAD or mid-HOLD SHALL discard the partial or pending frame with no spurious measurements_valid.

Structure
REQ-034 START_DECODING_MSG (8'h01), MEASUREMENT_DATA_HEADER (8'h02), and the parser state enum SHALL live in the shared parameters package.
REQ-035 The compaction SHALL be one natural sub-module, measurement_compactor (purely combinational, padded-to-packed), instantiated once.
REQ-036 The counter width SHALL be $clog2(FRAME_BYTES+1).

Verification (defaults: PU_PER_ROUND=6, BYTES_PER_ROUND=1, FRAME_BYTES=3)
REQ-037 Scenario: send 01, 02, 3F, 21, 00 with measurements_ready=1 -> start_pulse for 1 cycle, measurements=18'h0087F (round0=6'h3F, round1=6'h21, round2=0), measurements_valid for exactly 1 cycle, one cycle after byte 3.
REQ-038 Scenario: send 02 before 01 -> error_count=1, FSM stays in WAIT_START, then 01 -> start_pulse.
REQ-039 Scenario: send a frame with bytes C0, C0, C0 -> pad bits ignored and measurements=0.
REQ-040 Scenario: hold measurements_ready=0 for 10 cycles after a frame -> input_ready=0 and measurements stable for all 10 cycles, then measurements_ready=1 -> IDLE with input_ready=1.
REQ-041 Scenario: random input_valid gaps across 50 frames -> every frame matches the model.
REQ-042 Scenario: 300 junk bytes in IDLE -> error_count=FF.
REQ-043 Scenario: reset after byte 2 of LOAD -> no measurements_valid, FSM in WAIT_START.

Source files
------------

// File: rtl/message_input_parser_pkg.sv
// Shared message codes, parser state type and sizing helper for the host
// message input parser and its measurement compactor.
package message_input_parser_pkg;

   localparam logic [7:0] START_DECODING_MSG      = 8'h01;
   localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

   typedef enum logic [1:0] {
      WAIT_START,
      IDLE,
      LOAD,
      HOLD
   } parser_state_e;

   // Number of whole bytes needed to carry one round of PU bits.
   function automatic int bytes_for_bits(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/message_input_parser_compactor.sv
// Purely combinational repacking of a byte-padded frame into a dense
// syndrome vector: each round's pad bits are dropped.
module measurement_compactor
   import message_input_parser_pkg::*;
#(
   parameter int GRID_WIDTH_X = 3,
   parameter int GRID_WIDTH_Z = 2,
   parameter int GRID_WIDTH_U = 3,
   localparam int PU_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z,
   localparam int ROUND_BITS   = bytes_for_bits(PU_PER_ROUND) * 8,
   localparam int PADDED_BITS  = ROUND_BITS * GRID_WIDTH_U,
   localparam int PU_COUNT     = PU_PER_ROUND * GRID_WIDTH_U
) (
   input  logic [PADDED_BITS-1:0] padded,
   output logic [PU_COUNT-1:0]    packed_meas
);

   // Walk every padded bit so pad positions are visibly consumed and skipped.
   always_comb begin
      packed_meas = '0;
      for (int unsigned b = 0; b < PADDED_BITS; b++) begin
         if ((b % ROUND_BITS) < PU_PER_ROUND) begin
            packed_meas[(b / ROUND_BITS) * PU_PER_ROUND + (b % ROUND_BITS)] = padded[b];
         end
      end
   end

endmodule

// File: rtl/message_input_parser.sv
// Host byte-stream parser: waits for a start command, then collects
// header-prefixed measurement frames and presents them compacted.
module message_input_parser
   import message_input_parser_pkg::*;
#(
   parameter int GRID_WIDTH_X = 3,
   parameter int GRID_WIDTH_Z = 2,
   parameter int GRID_WIDTH_U = 3,
   localparam int PU_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z,
   localparam int PU_COUNT     = PU_PER_ROUND * GRID_WIDTH_U
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          input_data,
   input  logic                input_valid,
   output logic                input_ready,
   output logic                start_pulse,
   output logic [PU_COUNT-1:0] measurements,
   output logic                measurements_valid,
   input  logic                measurements_ready,
   output logic [7:0]          error_count
);

   localparam int BYTES_PER_ROUND = bytes_for_bits(PU_PER_ROUND);
   localparam int FRAME_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U;
   localparam int PADDED_BITS     = FRAME_BYTES * 8;
   localparam int CNT_W           = $clog2(FRAME_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

   parser_state_e          state_q, state_d;
   logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
   logic [PADDED_BITS-1:0] padded_q, padded_d;
   logic [PU_COUNT-1:0]    meas_q, meas_d;
   logic                   start_pulse_q, start_pulse_d;
   logic [7:0]             error_count_q, error_count_d;
   logic [PU_COUNT-1:0]    compacted;
   logic                   accept;

   assign input_ready        = (state_q != HOLD);
   assign measurements_valid = (state_q == HOLD);
   assign accept             = input_valid && input_ready;

   // Buffer update is split out so the compactor sees the frame including
   // the byte landing this cycle, letting measurements register at t+1.
   always_comb begin
      padded_d = padded_q;
      if (accept && state_q == LOAD) begin
         padded_d[{byte_cnt_q, 3'b000} +: 8] = input_data;
      end
   end

   measurement_compactor #(
      .GRID_WIDTH_X (GRID_WIDTH_X),
      .GRID_WIDTH_Z (GRID_WIDTH_Z),
      .GRID_WIDTH_U (GRID_WIDTH_U)
   ) u_compactor (
      .padded      (padded_d),
      .packed_meas (compacted)
   );

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      meas_d        = meas_q;
      start_pulse_d = 1'b0;
      error_count_d = error_count_q;
      unique case (state_q)
         WAIT_START: begin
            if (accept) begin
               if (input_data == START_DECODING_MSG) begin
                  state_d       = IDLE;
                  start_pulse_d = 1'b1;
               end else if (error_count_q != 8'hFF) begin
                  error_count_d = error_count_q + 8'd1;
               end
            end
         end
         IDLE: begin
            if (accept) begin
               if (input_data == MEASUREMENT_DATA_HEADER) begin
                  state_d    = LOAD;
                  byte_cnt_d = '0;
               end else if (input_data == START_DECODING_MSG) begin
                  start_pulse_d = 1'b1;
               end else if (error_count_q != 8'hFF) begin
                  error_count_d = error_count_q + 8'd1;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (byte_cnt_q == LAST_BYTE) begin
                  state_d = HOLD;
                  meas_d  = compacted;
               end
            end
         end
         HOLD: begin
            if (measurements_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = WAIT_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= WAIT_START;
         byte_cnt_q    <= '0;
         padded_q      <= '0;
         meas_q        <= '0;
         start_pulse_q <= 1'b0;
         error_count_q <= '0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         padded_q      <= padded_d;
         meas_q        <= meas_d;
         start_pulse_q <= start_pulse_d;
         error_count_q <= error_count_d;
      end
   end

   assign start_pulse  = start_pulse_q;
   assign measurements = meas_q;
   assign error_count  = error_count_q;

endmodule

// File: tb/tb_message_input_parser.sv
// Self-checking bench: transaction-level model of the host protocol compared
// against the parser every cycle, plus directed literal expectations.
module tb_message_input_parser;

   localparam int GX  = 3;
   localparam int GZ  = 2;
   localparam int GU  = 3;
   localparam int PPR = GX * GZ;
   localparam int BPR = (PPR + 7) / 8;
   localparam int FB  = BPR * GU;
   localparam int PUC = PPR * GU;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [7:0]     input_data = '0;
   logic           input_valid = 1'b0;
   logic           input_ready;
   logic           start_pulse;
   logic [PUC-1:0] measurements;
   logic           measurements_valid;
   logic           measurements_ready = 1'b0;
   logic [7:0]     error_count;

   int n_checks = 0;
   int n_errors = 0;
   int n_handshakes = 0;
   bit rand_ready = 1'b0;

   always #5 clk = ~clk;

   message_input_parser #(
      .GRID_WIDTH_X (GX),
      .GRID_WIDTH_Z (GZ),
      .GRID_WIDTH_U (GU)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .input_data         (input_data),
      .input_valid        (input_valid),
      .input_ready        (input_ready),
      .start_pulse        (start_pulse),
      .measurements       (measurements),
      .measurements_valid (measurements_valid),
      .measurements_ready (measurements_ready),
      .error_count        (error_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference packing: round k occupies bytes [k*BPR, k*BPR+BPR); only its
   // first PPR bits are syndrome bits.
   function automatic logic [PUC-1:0] pack_frame(input logic [7:0] bytes[$]);
      logic [PUC-1:0] r = '0;
      for (int k = 0; k < GU; k++) begin
         for (int p = 0; p < PPR; p++) begin
            int pb = k * BPR * 8 + p;
            logic [7:0] by = bytes[pb / 8];
            r[k * PPR + p] = by[pb % 8];
         end
      end
      return r;
   endfunction

   bit             model_on = 1'b0;
   bit             m_started, m_loading, m_holding, m_pulse;
   int             m_err;
   logic [7:0]     m_bytes[$];
   logic [PUC-1:0] m_meas;

   always @(posedge clk) begin
      if (reset) begin
         model_on  = 1'b1;
         m_started = 1'b0;
         m_loading = 1'b0;
         m_holding = 1'b0;
         m_pulse   = 1'b0;
         m_err     = 0;
         m_meas    = '0;
         m_bytes.delete();
      end else if (model_on) begin
         m_pulse = 1'b0;
         if (m_holding) begin
            if (measurements_ready) m_holding = 1'b0;
         end else if (input_valid) begin
            if (m_loading) begin
               m_bytes.push_back(input_data);
               if (m_bytes.size() == FB) begin
                  m_meas    = pack_frame(m_bytes);
                  m_holding = 1'b1;
                  m_loading = 1'b0;
               end
            end else if (input_data == 8'h01) begin
               m_started = 1'b1;
               m_pulse   = 1'b1;
            end else if (m_started && input_data == 8'h02) begin
               m_loading = 1'b1;
               m_bytes.delete();
            end else if (m_err < 255) begin
               m_err++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("input_ready", 64'(input_ready), 64'(!m_holding));
         chk("measurements_valid", 64'(measurements_valid), 64'(m_holding));
         chk("start_pulse", 64'(start_pulse), 64'(m_pulse));
         chk("error_count", 64'(error_count), 64'(m_err));
         chk("measurements", 64'(measurements), 64'(m_meas));
         if (measurements_valid && measurements_ready) n_handshakes++;
      end
   end

   task tick();
      @(posedge clk);
      #1;
      if (rand_ready) measurements_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      input_valid = 1'b0;
      repeat (gap) tick();
      input_data  = b;
      input_valid = 1'b1;
      while (!input_ready) begin
         tick();
         n++;
         if (n > 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: input_ready=0 after %0d cycles, expected 1", n);
            break;
         end
      end
      tick();
      input_valid = 1'b0;
   endtask

   task do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1);
   end

   initial begin
      logic [7:0]     fb[$];
      logic [PUC-1:0] exp_m;
      int             hs0;

      repeat (3) tick();
      chk("reset_input_ready", 64'(input_ready), 64'd1);
      chk("reset_valid", 64'(measurements_valid), 64'd0);
      chk("reset_meas", 64'(measurements), 64'd0);
      reset = 1'b0;
      tick();

      // Basic frame with ready held high.
      measurements_ready = 1'b1;
      send_byte(8'h01, 0);
      chk("s1_start_pulse", 64'(start_pulse), 64'd1);
      tick();
      chk("s1_pulse_one_cycle", 64'(start_pulse), 64'd0);
      send_byte(8'h02, 0);
      send_byte(8'h3F, 0);
      send_byte(8'h21, 0);
      send_byte(8'h00, 0);
      chk("s1_valid", 64'(measurements_valid), 64'd1);
      chk("s1_meas", 64'(measurements), 64'h0087F);
      tick();
      chk("s1_valid_drop", 64'(measurements_valid), 64'd0);
      chk("s1_ready_back", 64'(input_ready), 64'd1);

      // Pad bits only.
      send_byte(8'h02, 0);
      repeat (FB) send_byte(8'hC0, 0);
      chk("s3_valid", 64'(measurements_valid), 64'd1);
      chk("s3_meas_zero", 64'(measurements), 64'd0);
      tick();

      // Header before start is dropped.
      do_reset();
      send_byte(8'h02, 0);
      chk("s2_err", 64'(error_count), 64'd1);
      chk("s2_no_pulse", 64'(start_pulse), 64'd0);
      send_byte(8'h01, 0);
      chk("s2_pulse", 64'(start_pulse), 64'd1);

      // Back-pressure for 10 cycles.
      measurements_ready = 1'b0;
      fb.delete();
      send_byte(8'h02, 1);
      for (int i = 0; i < FB; i++) begin
         fb.push_back(8'($urandom));
         send_byte(fb[i], 0);
      end
      exp_m = pack_frame(fb);
      for (int i = 0; i < 10; i++) begin
         chk("s4_ready_low", 64'(input_ready), 64'd0);
         chk("s4_meas_stable", 64'(measurements), 64'(exp_m));
         tick();
      end
      measurements_ready = 1'b1;
      tick();
      chk("s4_released", 64'(input_ready), 64'd1);
      chk("s4_valid_low", 64'(measurements_valid), 64'd0);

      // Random gaps and random downstream readiness.
      hs0 = n_handshakes;
      rand_ready = 1'b1;
      for (int f = 0; f < 50; f++) begin
         if ($urandom_range(0, 4) == 0) send_byte(8'h01, $urandom_range(0, 2));
         send_byte(8'h02, $urandom_range(0, 3));
         for (int b = 0; b < FB; b++) send_byte(8'($urandom), $urandom_range(0, 3));
      end
      rand_ready = 1'b0;
      measurements_ready = 1'b1;
      repeat (3) tick();
      chk("s5_frames_delivered", 64'(n_handshakes - hs0), 64'd50);

      // Junk in IDLE saturates the error counter.
      for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(3, 255)), 0);
      chk("s6_err_sat", 64'(error_count), 64'hFF);

      // Reset in the middle of LOAD.
      send_byte(8'h02, 0);
      send_byte(8'h5A, 0);
      send_byte(8'hA5, 0);
      do_reset();
      chk("s7_valid_low", 64'(measurements_valid), 64'd0);
      chk("s7_err_cleared", 64'(error_count), 64'd0);
      repeat (3) tick();
      send_byte(8'h02, 0);
      chk("s7_wait_start", 64'(error_count), 64'd1);

      // Reset while a frame is pending.
      measurements_ready = 1'b0;
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      repeat (FB) send_byte(8'h15, 0);
      chk("s8_pending", 64'(measurements_valid), 64'd1);
      do_reset();
      chk("s8_dropped", 64'(measurements_valid), 64'd0);
      chk("s8_meas_cleared", 64'(measurements), 64'd0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
